// File: rtl/ticket_queue_pkg.sv
// ticket_queue_pkg
// Shared constants and helpers for the multi-channel ticket queue.
// Holds the default geometry (ticket width, per-channel depth, channel count)
// and the derived pointer/count/RAM-address widths, plus usedw_slice() which
// extracts one channel's occupancy field from the packed usedw bus.
package ticket_queue_pkg;

  localparam int TQ_DATA_WIDTH = 68;
  localparam int TQ_DEPTH_LOG2 = 4;
  localparam int TQ_N_CH       = 4;
  localparam int TQ_CH_W       = 2;

  localparam int TQ_PTR_W  = TQ_DEPTH_LOG2;
  localparam int TQ_CNT_W  = TQ_DEPTH_LOG2 + 1;
  localparam int TQ_ADDR_W = TQ_CH_W + TQ_DEPTH_LOG2;

  // Occupancy of channel ch from a packed usedw bus of the default geometry.
  function automatic logic [TQ_CNT_W-1:0] usedw_slice(
    input logic [TQ_N_CH*TQ_CNT_W-1:0] usedw_vec,
    input int unsigned                 ch
  );
    return usedw_vec[ch*TQ_CNT_W +: TQ_CNT_W];
  endfunction

endpackage

// File: rtl/ticket_queue_mc_ram.sv
// ticket_ram
// Simple dual-port RAM backing all channel FIFOs. One write port, one read
// port, registered read data. A read and write to the same address in the
// same cycle returns the new data (write-first). The read register is cleared
// by rst so the queue presents rd_data = 0 after reset.
// Contents are undefined until written; the queue never reads a word that has
// not been written since its channel was last emptied.
// Ports:
//   clk, rst         clock, synchronous active-high reset (read register only)
//   we, waddr, wdata write port
//   re, raddr        read request; rdata updates on the next edge
//   rdata            registered read data, holds when re is low
module ticket_ram #(
  parameter int DATA_WIDTH = 68,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/ticket_queue_mc.sv
// ticket_queue_mc
// N_CH independent ticket FIFOs sharing one simple-dual-port RAM; channel c
// owns addresses {c, ptr}. One push and one pop per cycle on any channels.
// Pop data arrives one cycle after the accepted pop.
// Optional feature macro: TICKET_QUEUE_DROP_CNT_EN adds drop_cnt, one
// saturating 16-bit lane per channel counting push attempts while full.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_valid, wr_ch, wr_data  push request; wr_ready = accepted this cycle
//   rd_en, rd_ch              pop request
//   rd_valid, rd_data         popped ticket, one cycle after accept
//   rd_data_ch                channel of the popped ticket
//   flush                     per-channel clear mask (wins over push/pop)
//   empty, full, usedw        per-channel status from registered counts
//   drop_cnt                  (macro only) per-channel rejected-push counters
module ticket_queue_mc
  import ticket_queue_pkg::*;
#(
  parameter int DATA_WIDTH = TQ_DATA_WIDTH,
  parameter int DEPTH_LOG2 = TQ_DEPTH_LOG2,
  parameter int N_CH       = TQ_N_CH,
  parameter int CH_W       = TQ_CH_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  input  logic [CH_W-1:0]                wr_ch,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_ready,
  input  logic                           rd_en,
  input  logic [CH_W-1:0]                rd_ch,
  output logic                           rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [CH_W-1:0]                rd_data_ch,
  input  logic [N_CH-1:0]                flush,
  output logic [N_CH-1:0]                empty,
  output logic [N_CH-1:0]                full,
  output logic [N_CH*(DEPTH_LOG2+1)-1:0] usedw
`ifdef TICKET_QUEUE_DROP_CNT_EN
  ,
  output logic [N_CH*16-1:0]             drop_cnt
`endif
);

  localparam int PTR_W  = DEPTH_LOG2;
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int ADDR_W = CH_W + DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2**DEPTH_LOG2);

  logic [PTR_W-1:0] wr_ptr [N_CH];
  logic [PTR_W-1:0] rd_ptr [N_CH];
  logic [CNT_W-1:0] count  [N_CH];

  logic             pop_acc;
  logic [N_CH-1:0]  push_hit;
  logic [N_CH-1:0]  pop_hit;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;

  // Status decode from registered counts.
  always_comb begin
    empty = '0;
    full  = '0;
    usedw = '0;
    for (int c = 0; c < N_CH; c++) begin
      empty[c]                   = (count[c] == '0);
      full[c]                    = (count[c] == CNT_FULL);
      usedw[c*CNT_W +: CNT_W]    = count[c];
    end
  end

  // Accept gating: these are the only paths that change pointers or counts,
  // so counts can never overflow or underflow.
  assign wr_ready = wr_valid & ~full[wr_ch] & ~flush[wr_ch];
  assign pop_acc  = rd_en & ~empty[rd_ch] & ~flush[rd_ch];

  always_comb begin
    push_hit = '0;
    pop_hit  = '0;
    if (wr_ready) push_hit[wr_ch] = 1'b1;
    if (pop_acc)  pop_hit[rd_ch]  = 1'b1;
  end

  assign waddr = {wr_ch, wr_ptr[wr_ch]};
  assign raddr = {rd_ch, rd_ptr[rd_ch]};

  // Per-channel pointer and count update; flush overrides push/pop.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (rst || flush[c]) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end else begin
        if (push_hit[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop_hit[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        case ({push_hit[c], pop_hit[c]})
          2'b10:   count[c] <= count[c] + 1'b1;
          2'b01:   count[c] <= count[c] - 1'b1;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  // Read pipeline stage: valid and channel tag travel with the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid   <= 1'b0;
      rd_data_ch <= '0;
    end else begin
      rd_valid <= pop_acc;
      if (pop_acc) rd_data_ch <= rd_ch;
    end
  end

  ticket_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ready),
    .waddr (waddr),
    .wdata (wr_data),
    .re    (pop_acc),
    .raddr (raddr),
    .rdata (rd_data)
  );

`ifdef TICKET_QUEUE_DROP_CNT_EN
  logic [15:0] drop_lane [N_CH];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (rst || flush[c]) begin
        drop_lane[c] <= '0;
      end else if (wr_valid && (wr_ch == CH_W'(c)) && full[c]) begin
        drop_lane[c] <= sat_inc16(drop_lane[c]);
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int c = 0; c < N_CH; c++) begin
      drop_cnt[c*16 +: 16] = drop_lane[c];
    end
  end
`endif

endmodule
